// File: rtl/hex_line_tx.sv
// hex_line_tx: prints each accepted binary word as an ASCII hex line, MSB nibble first,
// optionally terminated by CR LF, into the usb_cdc IN byte stream.
// Ports: clk_i/rstn_i (clock, async active-low reset); word_i/word_valid_i/word_ready_o
// (word handshake, ready only while idle); in_data_o/in_valid_o/in_ready_i (byte stream).
// First byte is valid one cycle after accept; a line is WORD_NIBBLES + 2*CRLF bytes, and
// the output byte holds steady while in_ready_i is low.
module hex_line_tx #(
  parameter int WORD_NIBBLES = 8,
  parameter bit UPPERCASE    = 1'b1,
  parameter bit CRLF         = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [4*WORD_NIBBLES-1:0] word_i,
  input  logic                      word_valid_i,
  output logic                      word_ready_o,
  output logic [7:0]                in_data_o,
  output logic                      in_valid_o,
  input  logic                      in_ready_i
);

  // Index width kept at least 1 bit so a single-nibble build still has a legal vector.
  localparam int IW = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(WORD_NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEX, S_CR, S_LF} state_t;

  state_t                    state_q, state_nxt;
  logic [4*WORD_NIBBLES-1:0] word_q, word_nxt;
  logic [IW-1:0]             idx_q, idx_nxt;
  logic [7:0]                data_nxt;
  logic                      valid_nxt;
  logic                      xfer;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] a;
    if (n < 4'd10) a = 8'h30 + {4'h0, n};
    else           a = (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    return a;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [4*WORD_NIBBLES-1:0] w,
                                           input logic [IW-1:0] idx);
    logic [3:0] n;
    n = 4'h0;
    for (int i = 0; i < WORD_NIBBLES; i++) begin
      if (idx == IW'(i)) n = w[4*i +: 4];
    end
    return n;
  endfunction

  assign xfer = in_valid_o & in_ready_i;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      in_data_o  <= 8'h00;
      in_valid_o <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      word_q     <= word_nxt;
      idx_q      <= idx_nxt;
      in_data_o  <= data_nxt;
      in_valid_o <= valid_nxt;
    end
  end

  // Next-state logic. Everything holds by default, which is what keeps the byte stable
  // across stalled cycles.
  always_comb begin
    state_nxt = state_q;
    word_nxt  = word_q;
    idx_nxt   = idx_q;
    data_nxt  = in_data_o;
    valid_nxt = in_valid_o;
    unique case (state_q)
      S_IDLE: begin
        valid_nxt = 1'b0;
        if (word_valid_i) begin
          // The first digit comes straight from word_i so it is valid one cycle after accept.
          word_nxt  = word_i;
          idx_nxt   = TOP_IDX;
          data_nxt  = hex_ascii(nibble_at(word_i, TOP_IDX));
          valid_nxt = 1'b1;
          state_nxt = S_HEX;
        end
      end
      S_HEX: begin
        if (xfer) begin
          if (idx_q != '0) begin
            idx_nxt  = idx_q - 1'b1;
            data_nxt = hex_ascii(nibble_at(word_q, idx_q - 1'b1));
          end else if (CRLF) begin
            data_nxt  = 8'h0D;
            state_nxt = S_CR;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = S_IDLE;
          end
        end
      end
      S_CR: begin
        if (xfer) begin
          data_nxt  = 8'h0A;
          state_nxt = S_LF;
        end
      end
      S_LF: begin
        if (xfer) begin
          valid_nxt = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    word_ready_o = (state_q == S_IDLE);
  end

endmodule

// File: tb/tb_hex_line_tx.sv
module tb_hex_line_tx;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;
  int          ready_mode = 0;  // 0: always ready, 1: one cycle in three, 2: random

  // Instance A: defaults (8 digits, uppercase, CR LF).
  logic [31:0] a_word = '0;
  logic        a_wvld = 1'b0, a_wrdy, a_vld, a_rdy = 1'b1;
  logic [7:0]  a_dat;
  // Instance B: 2 digits, lowercase, no terminator.
  logic [7:0]  b_word = '0;
  logic        b_wvld = 1'b0, b_wrdy, b_vld, b_rdy = 1'b1;
  logic [7:0]  b_dat;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  int          xfer_a = 0;

  hex_line_tx u_a (
    .clk_i(clk), .rstn_i(rstn), .word_i(a_word), .word_valid_i(a_wvld),
    .word_ready_o(a_wrdy), .in_data_o(a_dat), .in_valid_o(a_vld), .in_ready_i(a_rdy)
  );

  hex_line_tx #(.WORD_NIBBLES(2), .UPPERCASE(1'b0), .CRLF(1'b0)) u_b (
    .clk_i(clk), .rstn_i(rstn), .word_i(b_word), .word_valid_i(b_wvld),
    .word_ready_o(b_wrdy), .in_data_o(b_dat), .in_valid_o(b_vld), .in_ready_i(b_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the text a word prints as, built from the digit rules directly.
  function automatic bq_t line_bytes(input logic [31:0] w, input int nib, input bit upper,
                                     input bit crlf);
    bq_t q;
    int  n;
    for (int i = nib - 1; i >= 0; i--) begin
      n = int'((w >> (4 * i)) & 32'hF);
      if (n < 10) q.push_back(8'(48 + n));
      else        q.push_back(8'((upper ? 65 : 97) + n - 10));
    end
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction

  // Byte-side ready pattern, changed just after the edge so it is stable when sampled.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 3;
      case (ready_mode)
        0: begin a_rdy = 1'b1; b_rdy = 1'b1; end
        1: begin a_rdy = (ph == 0); b_rdy = (ph == 0); end
        default: begin a_rdy = 1'($urandom_range(0, 1)); b_rdy = 1'($urandom_range(0, 1)); end
      endcase
    end
  end

  // Monitor A: pops the scoreboard on each transfer and checks stall stability.
  initial begin
    logic       hold = 1'b0;
    logic [7:0] prev = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("a_stall_valid", a_vld, 1);
          chk("a_stall_data", a_dat, prev);
        end
        if (a_vld && a_rdy) begin
          if (qa.size() == 0) chk("a_unexpected_byte", a_dat, 32'hFFFF_FFFF);
          else begin
            e = qa.pop_front();
            chk("a_byte", a_dat, e);
          end
          xfer_a++;
        end
        hold = a_vld && !a_rdy;
        prev = a_dat;
      end
    end
  end

  // Monitor B.
  initial begin
    logic       hold = 1'b0;
    logic [7:0] prev = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("b_stall_valid", b_vld, 1);
          chk("b_stall_data", b_dat, prev);
        end
        if (b_vld && b_rdy) begin
          if (qb.size() == 0) chk("b_unexpected_byte", b_dat, 32'hFFFF_FFFF);
          else begin
            e = qb.pop_front();
            chk("b_byte", b_dat, e);
          end
        end
        hold = b_vld && !b_rdy;
        prev = b_dat;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with valid low.
  task automatic send_a(input logic [31:0] w, output int acc);
    bq_t q;
    int  t = 0;
    a_word = w;
    a_wvld = 1'b1;
    while (!a_wrdy && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("a_accept_timeout", 32'(t < 500), 1);
    acc = cyc;
    q = line_bytes(w, 8, 1'b1, 1'b1);
    foreach (q[i]) qa.push_back(q[i]);
    @(negedge clk);
    a_wvld = 1'b0;
    a_word = $urandom;  // word_i changes after accept must not matter
  endtask

  task automatic send_b(input logic [7:0] w);
    bq_t q;
    int  t = 0;
    b_word = w;
    b_wvld = 1'b1;
    while (!b_wrdy && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("b_accept_timeout", 32'(t < 500), 1);
    q = line_bytes({24'h0, w}, 2, 1'b0, 1'b0);
    foreach (q[i]) qb.push_back(q[i]);
    @(negedge clk);
    b_wvld = 1'b0;
    b_word = 8'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0 || !a_wrdy || !b_wrdy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(t < 2000), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, base, t;
    // Reset state.
    #12;
    chk("rst_word_ready", a_wrdy, 1);
    chk("rst_valid", a_vld, 0);
    chk("rst_data", a_dat, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Test 1: DEADBEEF at full rate, exact timing.
    ready_mode = 0;
    @(negedge clk);
    send_a(32'hDEADBEEF, a1);
    for (int k = 0; k < 10; k++) begin
      chk("t1_valid_run", a_vld, 1);
      chk("t1_ready_low", a_wrdy, 0);
      @(negedge clk);
    end
    chk("t1_ready_back", a_wrdy, 1);
    chk("t1_valid_end", a_vld, 0);
    chk("t1_q_empty", qa.size(), 0);

    // Test 2: same word with one-in-three ready.
    ready_mode = 1;
    send_a(32'hDEADBEEF, a1);
    drain();

    // Test 4: two lowercase digits, no terminator.
    ready_mode = 0;
    @(negedge clk);
    send_b(8'h5A);
    chk("t4_b0_valid", b_vld, 1);
    @(negedge clk);
    chk("t4_b1_valid", b_vld, 1);
    @(negedge clk);
    chk("t4_end_valid", b_vld, 0);
    chk("t4_end_ready", b_wrdy, 1);

    // Test 5: queued words, second accept one cycle after the LF transfer.
    send_a(32'h0000_0001, a1);
    send_a(32'h1234_5678, a2);
    chk("t5_spacing", a2 - a1, 11);
    drain();

    // Random words on both instances with random ready.
    ready_mode = 2;
    for (int i = 0; i < 25; i++) send_a($urandom, a1);
    drain();
    for (int i = 0; i < 25; i++) send_b(8'($urandom));
    drain();

    // Test 6: asynchronous reset mid-line.
    ready_mode = 1;
    base = xfer_a;
    send_a(32'hCAFE_0123, a1);
    t = 0;
    while (xfer_a < base + 3 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("t6_wait_timeout", 32'(t < 500), 1);
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", a_vld, 0);
    chk("t6_rst_ready", a_wrdy, 1);
    qa.delete();
    @(negedge clk);
    rstn = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    send_a(32'hFFFF_FFFF, a1);
    drain();

    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/hex_line_tx.md
Name: hex_line_tx

Overview:
- Application-side byte producer for the USB CDC IN (device-to-host) stream. It is the counterpart of the loopback app, which consumes the OUT stream.
- Accepts binary words over a valid/ready handshake. Each word is emitted as an ASCII hexadecimal line (MSB nibble first, optional CR LF) into the usb_cdc in_data/in_valid/in_ready interface.
- Runs in the app clock domain (12 MHz in the Fomu demo) and sits between user logic and u_usb_cdc.

Parameters:
- WORD_NIBBLES, 8, number of hex digits per word. Legal range 1..8; word_i width is 4*WORD_NIBBLES.
- UPPERCASE, 1, 1: digits A-F encode as 0x41-0x46; 0: a-f encode as 0x61-0x66.
- CRLF, 1, 1: append 0x0D then 0x0A after the last digit; 0: no line terminator.

Ports:
- clk_i  input  1  app clock. Single clock; all logic on the rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- word_i  input  4*WORD_NIBBLES  word to print. Sampled only on accept.
- word_valid_i  input  1  word_i valid.
- word_ready_o  output  1  block idle, can accept a word.
- in_data_o  output  8  ASCII byte to usb_cdc in_data_i.
- in_valid_o  output  1  in_data_o valid, to usb_cdc in_valid_i.
- in_ready_i  input  1  usb_cdc in_ready_o.

Behaviour:
- States: IDLE, HEX, CR, LF. Registers: state, captured word, nibble index, in_data_o, in_valid_o.
- Reset (async, rstn_i low):
  - state=IDLE, in_valid_o=0, in_data_o=8'h00, index=0.
  - word_ready_o=1, since it is decoded directly as state==IDLE.
  - Asserting reset mid-line aborts the line immediately. No partial-line resume after release.
- Word handshake: accept = word_valid_i & word_ready_o at a clock edge.
- Byte handshake: transfer = in_valid_o & in_ready_i at a clock edge.
  - While in_valid_o=1 and in_ready_i=0, in_data_o and in_valid_o hold stable.
  - in_valid_o never drops without a transfer, except on reset.
- IDLE:
  - in_valid_o=0.
  - On accept: capture word_i; index=WORD_NIBBLES-1; go to HEX.
  - On the same edge, load in_data_o with the ASCII of nibble [index] and set in_valid_o=1. First byte is valid one cycle after accept.
- HEX:
  - On transfer with index>0: decrement index; load the next nibble's ASCII; in_valid_o stays 1.
  - On transfer with index==0:
    - CRLF=1: go to CR, in_data_o=0x0D.
    - CRLF=0: go to IDLE, in_valid_o=0.
- CR: on transfer, go to LF, in_data_o=0x0A.
- LF: on transfer, go to IDLE, in_valid_o=0.
- Throughput:
  - With in_ready_i held 1, one byte per cycle.
  - A line is WORD_NIBBLES+2*CRLF bytes.
  - word_ready_o rises the cycle after the final transfer. Minimum accept-to-accept spacing is line length + 1 cycles.
- Encoding:
  - Nibble 0-9 encodes as 0x30+n.
  - Nibble 10-15 encodes as (UPPERCASE ? 0x41 : 0x61)+n-10.
  - Pure function of the captured nibble; no arithmetic overflow possible.
- Changes on word_i or word_valid_i while not IDLE are ignored; word_ready_o=0 outside IDLE.
- Simultaneous events: word_valid_i high in the same cycle as the final byte transfer is not accepted that cycle, because word_ready_o is still 0. It is accepted on the next cycle.
- Index wrap-around: not possible; index only decrements while >0.

Test Plan:
1. Defaults, word_i=0xDEADBEEF, one-cycle accept, in_ready_i=1 -> bytes 44 45 41 44 42 45 45 46 0D 0A on 10 consecutive cycles starting 1 cycle after accept; word_ready_o low exactly 10 cycles, then high.
2. Same word, in_ready_i high 1 of every 3 cycles -> identical byte sequence; in_data_o/in_valid_o stable across every stalled cycle; no byte duplicated or dropped.
3. UPPERCASE=0, word_i=0x0000ABCF -> 30 30 30 30 61 62 63 66 0D 0A.
4. WORD_NIBBLES=2, CRLF=0, word_i=0x5A -> 35 41 only, then in_valid_o=0 and word_ready_o=1 next cycle.
5. word_valid_i held high with 0x00000001 then 0x12345678 queued -> second accept occurs exactly 1 cycle after the first line's 0x0A transfer; second line 31 32 33 34 35 36 37 38 0D 0A.
6. rstn_i pulsed low asynchronously (mid-cycle) after the 3rd byte transfer -> in_valid_o=0 and word_ready_o=1 without waiting for a clock edge; after release, a new word 0xFFFFFFFF emits 46 x8 0D 0A with no residue of the aborted line.
